smc_step_period_sequencer: RTL

//  Avalon-MM master that drives the smc_soc interval-timer slave (16-bit regs: 0 status, 1 control, 2/3 period L/H,
//  4/5 snapshot). Takes a stream of 32-bit step periods, programs each one into the timer in one-shot mode,

---
 rtl/smc_step_period_sequencer.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/smc_step_period_sequencer.sv
// -----------------------------------------------------------------------------
// smc_step_period_sequencer
//
// Purpose:
//   Avalon-MM master for the smc_soc interval timer (16-bit registers:
//   0 status, 1 control, 2/3 period low/high, 4/5 snapshot). Step periods
//   arrive on a valid/ready stream and are buffered in a small FIFO. Each
//   period is programmed into the timer in one-shot mode. The sequencer then
//   waits for the timer IRQ, confirms the timeout in the status register,
//   clears it and emits one step pulse before loading the next period.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   enable             level; a rising edge while idle starts a run
//   abort              1-cycle pulse; stops the timer and flushes the FIFO
//   period_data/last/valid, period_ready
//                      period stream (transfer when valid & ready)
//   step_pulse         PULSE_CYC-wide pulse per confirmed timeout
//   busy               high whenever the sequencer is not idle
//   done               1-cycle pulse after the step of a "last" period
//   underrun           sticky; FIFO ran dry before a "last" period arrived
//   step_count         steps issued in the current run (wraps)
//   m_address, m_chipselect, m_write_n, m_writedata, m_readdata
//                      Avalon-MM master (no waitrequest, read data valid
//                      the cycle after the address)
//   timer_irq          timer interrupt input
// -----------------------------------------------------------------------------
module smc_step_period_sequencer #(
    parameter int DEPTH      = 16,
    parameter int PULSE_CYC  = 4,
    parameter int MIN_PERIOD = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        abort,
    input  logic [31:0] period_data,
    input  logic        period_last,
    input  logic        period_valid,
    output logic        period_ready,
    output logic        step_pulse,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic [15:0] step_count,
    output logic [2:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [15:0] m_writedata,
    input  logic [15:0] m_readdata,
    input  logic        timer_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    localparam logic [2:0]  REG_STATUS  = 3'd0;
    localparam logic [2:0]  REG_CONTROL = 3'd1;
    localparam logic [2:0]  REG_PERIODL = 3'd2;
    localparam logic [2:0]  REG_PERIODH = 3'd3;
    localparam logic [15:0] CTRL_STOP   = 16'h0008;
    localparam logic [15:0] CTRL_START  = 16'h0005;   // START | ITO, one-shot
    localparam logic [31:0] MIN_P       = 32'(MIN_PERIOD);

    typedef enum logic [3:0] {
        S_IDLE, S_STOP, S_LOAD, S_PL, S_PH, S_SETTLE, S_START,
        S_WAIT, S_RDA, S_RDD, S_CLR, S_STEP, S_HALT
    } state_t;

    // ------------------------------------------------------------------
    // Period FIFO: {last, period} entries, pointers carry a wrap bit.
    // ------------------------------------------------------------------
    logic [32:0] mem [DEPTH];
    logic [32:0] head_reg;
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [31:0] head_period;

    state_t      state_reg;

    assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                          (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign period_ready = !fifo_full;
    // abort wins over a simultaneous push; the flush discards everything.
    assign push         = period_valid && !fifo_full && !abort;
    assign pop          = (state_reg == S_LOAD) && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (abort) begin
            rd_ptr_reg <= wr_ptr_reg;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= {period_last, period_data};
    end

    // Registered head read. LOAD is always preceded by STOP or STEP, during
    // which the head entry is already stable in memory, so head_reg holds
    // the correct entry when LOAD uses it.
    always_ff @(posedge clk) begin
        head_reg <= mem[rd_ptr_reg[AW-1:0]];
    end

    assign head_period = (head_reg[31:0] < MIN_P) ? MIN_P : head_reg[31:0];

    // ------------------------------------------------------------------
    // Sequencer FSM with registered bus and status outputs. Bus registers
    // are loaded on entry to an access state, so they line up with it.
    // ------------------------------------------------------------------
    logic          enable_d_reg;
    logic [15:0]   period_hi_reg;
    logic          last_reg;
    logic          done_reg;
    logic          underrun_reg;
    logic [15:0]   step_count_reg;
    logic          cs_reg;
    logic          write_n_reg;
    logic [2:0]    addr_reg;
    logic [15:0]   wdata_reg;
    logic          pulse_reg;
    logic [PW-1:0] pulse_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            enable_d_reg   <= 1'b0;
            period_hi_reg  <= '0;
            last_reg       <= 1'b0;
            done_reg       <= 1'b0;
            underrun_reg   <= 1'b0;
            step_count_reg <= '0;
            cs_reg         <= 1'b0;
            write_n_reg    <= 1'b1;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            pulse_reg      <= 1'b0;
            pulse_cnt_reg  <= '0;
        end else begin
            enable_d_reg <= enable;
            done_reg     <= 1'b0;
            cs_reg       <= 1'b0;
            write_n_reg  <= 1'b1;
            addr_reg     <= '0;
            wdata_reg    <= '0;

            if (pulse_reg) begin
                if (pulse_cnt_reg == '0) pulse_reg     <= 1'b0;
                else                     pulse_cnt_reg <= pulse_cnt_reg - PW'(1);
            end

            if (abort) begin
                state_reg   <= S_HALT;
                cs_reg      <= 1'b1;
                write_n_reg <= 1'b0;
                addr_reg    <= REG_CONTROL;
                wdata_reg   <= CTRL_STOP;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (enable && !enable_d_reg && !fifo_empty) begin
                            state_reg      <= S_STOP;
                            step_count_reg <= '0;
                            underrun_reg   <= 1'b0;
                            cs_reg         <= 1'b1;
                            write_n_reg    <= 1'b0;
                            addr_reg       <= REG_CONTROL;
                            wdata_reg      <= CTRL_STOP;
                        end
                    end
                    S_STOP: state_reg <= S_LOAD;
                    S_LOAD: begin
                        period_hi_reg <= head_period[31:16];
                        last_reg      <= head_reg[32];
                        state_reg     <= S_PL;
                        cs_reg        <= 1'b1;
                        write_n_reg   <= 1'b0;
                        addr_reg      <= REG_PERIODL;
                        wdata_reg     <= head_period[15:0];
                    end
                    S_PL: begin
                        state_reg   <= S_PH;
                        cs_reg      <= 1'b1;
                        write_n_reg <= 1'b0;
                        addr_reg    <= REG_PERIODH;
                        wdata_reg   <= period_hi_reg;
                    end
                    // SETTLE gives the slave's period reload a quiet cycle
                    // before START, so the two cannot race.
                    S_PH: state_reg <= S_SETTLE;
                    S_SETTLE: begin
                        state_reg   <= S_START;
                        cs_reg      <= 1'b1;
                        write_n_reg <= 1'b0;
                        addr_reg    <= REG_CONTROL;
                        wdata_reg   <= CTRL_START;
                    end
                    S_START: state_reg <= S_WAIT;
                    S_WAIT: begin
                        if (timer_irq) begin
                            state_reg <= S_RDA;
                            cs_reg    <= 1'b1;
                            addr_reg  <= REG_STATUS;
                        end
                    end
                    S_RDA: state_reg <= S_RDD;
                    S_RDD: begin
                        // Status.TO clear means the IRQ was not a real timeout.
                        if (m_readdata[0]) begin
                            state_reg   <= S_CLR;
                            cs_reg      <= 1'b1;
                            write_n_reg <= 1'b0;
                            addr_reg    <= REG_STATUS;
                            wdata_reg   <= 16'h0000;
                        end else begin
                            state_reg <= S_WAIT;
                        end
                    end
                    S_CLR: begin
                        state_reg      <= S_STEP;
                        pulse_reg      <= 1'b1;
                        pulse_cnt_reg  <= PW'(PULSE_CYC - 1);
                        step_count_reg <= step_count_reg + 16'd1;
                    end
                    S_STEP: begin
                        if (last_reg) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_IDLE;
                        end else if (!enable) begin
                            state_reg <= S_IDLE;
                        end else if (!fifo_empty) begin
                            state_reg <= S_LOAD;
                        end else begin
                            underrun_reg <= 1'b1;
                            state_reg    <= S_HALT;
                            cs_reg       <= 1'b1;
                            write_n_reg  <= 1'b0;
                            addr_reg     <= REG_CONTROL;
                            wdata_reg    <= CTRL_STOP;
                        end
                    end
                    S_HALT:  state_reg <= S_IDLE;
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    // Only the TO bit of the status register matters here.
    logic unused_readdata;
    assign unused_readdata = ^m_readdata[15:1];

    assign busy         = (state_reg != S_IDLE);
    assign done         = done_reg;
    assign underrun     = underrun_reg;
    assign step_count   = step_count_reg;
    assign step_pulse   = pulse_reg;
    assign m_chipselect = cs_reg;
    assign m_write_n    = write_n_reg;
    assign m_address    = addr_reg;
    assign m_writedata  = wdata_reg;

endmodule
